// File: rtl/lcd_line_arbiter.sv
// Round-robin arbiter that lets NREQ sources each write one 16-character line
// into the shared 32-byte LCD buffer, then holds that line for HOLD cycles.
module lcd_line_arbiter #(
    parameter int NREQ   = 4,
    parameter int HOLD   = 50_000_000,
    parameter int HOLD_W = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     line,
    input  logic [8*NREQ-1:0]   chr_data,
    output logic [NREQ-1:0]     gnt,
    output logic [3:0]          chr_idx,
    output logic [NREQ-1:0]     done,
    output logic                busy,
    output logic                W,
    output logic [4:0]          WADD,
    output logic [7:0]          DIN
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t             state_reg;
    logic [NREQ-1:0]    gnt_reg;
    logic [NREQ-1:0]    done_reg;
    logic [3:0]         chr_idx_reg;
    logic               w_reg;
    logic [4:0]         wadd_reg;
    logic [7:0]         din_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [IDX_W-1:0]   sel_reg;
    logic               sel_line_reg;
    logic [HOLD_W-1:0]  hold_cnt_reg [2];

    logic [NREQ-1:0]    eligible;
    logic [NREQ-1:0]    elig_rot;
    logic [IDX_W-1:0]   cand [NREQ];
    logic [7:0]         chr_arr [NREQ];
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   rr_next;

    // cand[k] is the requester visited k-th in the scan starting at rr_ptr
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign eligible[gi] = req[gi] && (hold_cnt_reg[line[gi]] == '0);
            assign cand[gi]     = IDX_W'((int'(rr_ptr_reg) + gi) % NREQ);
            assign elig_rot[gi] = eligible[cand[gi]];
            assign chr_arr[gi]  = chr_data[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                pick_found = 1'b1;
                pick_idx   = cand[k];
            end
        end
    end

    assign rr_next = (sel_reg == IDX_W'(NREQ - 1)) ? '0 : sel_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            done_reg     <= '0;
            chr_idx_reg  <= '0;
            w_reg        <= 1'b0;
            wadd_reg     <= '0;
            din_reg      <= '0;
            rr_ptr_reg   <= '0;
            sel_reg      <= '0;
            sel_line_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= '0;
                    w_reg    <= 1'b0;
                    if (pick_found) begin
                        sel_reg      <= pick_idx;
                        sel_line_reg <= line[pick_idx];
                        gnt_reg      <= NREQ'(1) << pick_idx;
                        chr_idx_reg  <= '0;
                        state_reg    <= WRITE;
                    end
                end
                WRITE: begin
                    // chr_data answers the chr_idx presented this cycle
                    w_reg    <= 1'b1;
                    wadd_reg <= {sel_line_reg, chr_idx_reg};
                    din_reg  <= chr_arr[sel_reg];
                    if (chr_idx_reg == 4'd15) begin
                        gnt_reg   <= '0;
                        done_reg  <= NREQ'(1) << sel_reg;
                        state_reg <= DONE;
                    end else begin
                        chr_idx_reg <= chr_idx_reg + 4'd1;
                    end
                end
                DONE: begin
                    done_reg   <= '0;
                    w_reg      <= 1'b0;
                    rr_ptr_reg <= rr_next;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-line hold timers; the reload on completion beats the decrement
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hold
            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_cnt_reg[gi] <= '0;
                end else if (state_reg == DONE && sel_line_reg == 1'(gi)) begin
                    hold_cnt_reg[gi] <= HOLD_W'(HOLD);
                end else if (hold_cnt_reg[gi] != '0) begin
                    hold_cnt_reg[gi] <= hold_cnt_reg[gi] - 1'b1;
                end
            end
        end
    endgenerate

    assign gnt     = gnt_reg;
    assign done    = done_reg;
    assign chr_idx = chr_idx_reg;
    assign busy    = (state_reg != IDLE);
    assign W       = w_reg;
    assign WADD    = wadd_reg;
    assign DIN     = din_reg;

endmodule

// File: tb/tb_lcd_line_arbiter.sv
// Directed bench: one arbiter with HOLD=100 and one with HOLD=0 share the same
// request inputs; the bench observes whichever instance a step selects.
module tb_lcd_line_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  line;
    logic [31:0] chr_data_a, chr_data_b;
    logic [3:0]  a_gnt, a_done, b_gnt, b_done;
    logic [3:0]  a_chr_idx, b_chr_idx;
    logic        a_busy, a_w, b_busy, b_w;
    logic [4:0]  a_wadd, b_wadd;
    logic [7:0]  a_din, b_din;
    logic        use_b;

    logic [3:0]  obs_gnt, obs_done, obs_chr_idx;
    logic        obs_busy, obs_w;
    logic [4:0]  obs_wadd;
    logic [7:0]  obs_din;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lcd_line_arbiter #(.NREQ(4), .HOLD(100), .HOLD_W(26)) dut_a (
        .clk(clk), .rst(rst), .req(req), .line(line), .chr_data(chr_data_a),
        .gnt(a_gnt), .chr_idx(a_chr_idx), .done(a_done), .busy(a_busy),
        .W(a_w), .WADD(a_wadd), .DIN(a_din)
    );

    lcd_line_arbiter #(.NREQ(4), .HOLD(0), .HOLD_W(26)) dut_b (
        .clk(clk), .rst(rst), .req(req), .line(line), .chr_data(chr_data_b),
        .gnt(b_gnt), .chr_idx(b_chr_idx), .done(b_done), .busy(b_busy),
        .W(b_w), .WADD(b_wadd), .DIN(b_din)
    );

    // Requester i answers index c with 8'h41 + c + 8'h20*i
    always_comb begin
        chr_data_a = '0;
        chr_data_b = '0;
        for (int i = 0; i < 4; i++) begin
            chr_data_a[8*i +: 8] = 8'h41 + {4'h0, a_chr_idx} + 8'(32 * i);
            chr_data_b[8*i +: 8] = 8'h41 + {4'h0, b_chr_idx} + 8'(32 * i);
        end
    end

    assign obs_gnt     = use_b ? b_gnt     : a_gnt;
    assign obs_done    = use_b ? b_done    : a_done;
    assign obs_chr_idx = use_b ? b_chr_idx : a_chr_idx;
    assign obs_busy    = use_b ? b_busy    : a_busy;
    assign obs_w       = use_b ? b_w       : a_w;
    assign obs_wadd    = use_b ? b_wadd    : a_wadd;
    assign obs_din     = use_b ? b_din     : a_din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        line = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"},  32'(obs_gnt), 0);
        chk({tag, "_done"}, 32'(obs_done), 0);
        chk({tag, "_busy"}, 32'(obs_busy), 0);
        chk({tag, "_idx"},  32'(obs_chr_idx), 0);
        chk({tag, "_w"},    32'(obs_w), 0);
        chk({tag, "_wadd"}, 32'(obs_wadd), 0);
        chk({tag, "_din"},  32'(obs_din), 0);
    endtask

    // Waits (bounded) for a grant; checks cycles taken and who got it
    task automatic wait_gnt(input int exp_n, input int r, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (obs_gnt == '0 && n < 300);
        chk({tag, "_lat"}, n, exp_n);
        chk({tag, "_gnt"}, 32'(obs_gnt), 1 << r);
        $display("grant %s: requester %0d after %0d cycles", tag, r, n);
    endtask

    // Called at the first grant cycle; follows the 16 writes and done pulse
    task automatic txn(input int r, input int l, input int drop_idx, input bit drop_done,
                       input string tag);
        chk({tag, "_idx0"}, 32'(obs_chr_idx), 0);
        chk({tag, "_w0"},   32'(obs_w), 0);
        chk({tag, "_busy"}, 32'(obs_busy), 1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("%s_w%0d", tag, k),    32'(obs_w), 1);
            chk($sformatf("%s_wadd%0d", tag, k), 32'(obs_wadd), (l << 4) | k);
            chk($sformatf("%s_din%0d", tag, k),  32'(obs_din), 8'h41 + k + 32 * r);
            if (k == 14) chk({tag, "_gnt_last"}, 32'(obs_gnt), 1 << r);
            if (k == 15) begin
                chk({tag, "_gnt_off"}, 32'(obs_gnt), 0);
                chk({tag, "_done"},    32'(obs_done), 1 << r);
            end
            if (k + 1 == drop_idx) req[r] = 1'b0;
        end
        if (drop_done) req[r] = 1'b0;
        @(negedge clk);
        chk({tag, "_w_end"},    32'(obs_w), 0);
        chk({tag, "_done_end"}, 32'(obs_done), 0);
        chk({tag, "_idle"},     32'(obs_busy), 0);
        $display("txn %s: requester %0d wrote line %0d", tag, r, l);
    endtask

    initial begin
        use_b = 1'b0;
        do_reset();
        chk_idle_outputs("reset");

        // Single write to the bottom line
        line[0] = 1'b1;
        req[0]  = 1'b1;
        wait_gnt(1, 0, "single");
        txn(0, 1, -1, 1, "single");

        // Simultaneous requests, then rotation past requester 2 to 3
        do_reset();
        line = 4'b0100;
        req  = 4'b0101;
        wait_gnt(1, 0, "rr_a");
        txn(0, 0, -1, 1, "rr_a");
        wait_gnt(1, 2, "rr_b");
        txn(2, 1, -1, 1, "rr_b");
        repeat (130) @(negedge clk);
        line = 4'b1100;
        req  = 4'b1101;
        wait_gnt(1, 3, "rr_c");
        txn(3, 1, -1, 1, "rr_c");
        wait_gnt(1, 0, "rr_d");
        txn(0, 0, -1, 1, "rr_d");
        @(negedge clk);
        chk("rr_held_line", 32'(obs_gnt), 0);
        req[2] = 1'b0;

        // Line hold blocks line 0 but not line 1
        do_reset();
        req[1] = 1'b1;
        wait_gnt(1, 1, "hold_first");
        txn(1, 0, -1, 1, "hold_first");
        line = 4'b1000;
        req  = 4'b1100;
        wait_gnt(1, 3, "hold_other");
        txn(3, 1, -1, 1, "hold_other");
        wait_gnt(83, 2, "hold_wait");
        txn(2, 0, -1, 1, "hold_wait");

        // Request dropped mid-line: line completes and hold still loads
        do_reset();
        req[0] = 1'b1;
        wait_gnt(1, 0, "drop");
        txn(0, 0, 5, 0, "drop");
        req[0] = 1'b1;
        wait_gnt(101, 0, "drop_hold");

        // Reset in the middle of a write
        do_reset();
        line[1] = 1'b1;
        req[1]  = 1'b1;
        wait_gnt(1, 1, "abort");
        repeat (7) @(negedge clk);
        chk("abort_idx7", 32'(obs_chr_idx), 7);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("abort_rst");
        rst = 1'b0;
        wait_gnt(1, 1, "restart");
        txn(1, 1, -1, 1, "restart");

        // HOLD=0: same line rewritten back-to-back
        do_reset();
        use_b  = 1'b1;
        req[0] = 1'b1;
        wait_gnt(1, 0, "b2b_a");
        txn(0, 0, -1, 0, "b2b_a");
        wait_gnt(1, 0, "b2b_b");
        txn(0, 0, -1, 1, "b2b_b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
